fizzbuzz_tx_gen: RTL
====================

FIZZBUZZ_TX_GEN -- requirements
Module: fizzbuzz_tx_gen

Interface
REQ-001 SHALL have parameter MAX_N, default 100, meaning last number emitted (legal range 1..999).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  pulse; begins a run from N=1 when idle.
REQ-005 SHALL have port tx_data  output  8  ASCII byte offered to UART transmitter.
REQ-006 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-007 SHALL have port tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-008 SHALL have port busy  output  1  high from start acceptance until run completes.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of run.

Function
REQ-010 SHALL, for each N = 1..MAX_N in order, emit one line: "FizzBuzz" if N mod 15 = 0, else "Fizz" if N mod 3 = 0, else "Buzz" if N mod 5 = 0, else decimal N, followed by the line terminator.
REQ-011 SHALL print decimal N most-significant digit first, no leading zeros, digits as ASCII 0x30..0x39.
REQ-012 SHALL track N as a 3-digit BCD counter with mod-3 (0..2) and mod-5 (0..4) counters; no divider.
REQ-013 SHALL implement states IDLE, WORD (Fizz/Buzz/FizzBuzz bytes), DIGITS, TERM (terminator bytes), NEXT (advance N or finish).
REQ-014 SHALL transition IDLE->WORD/DIGITS on start while busy=0; WORD/DIGITS->TERM after last character byte transfers; TERM->NEXT after last terminator byte transfers; NEXT->IDLE if N=MAX_N, else next line.
REQ-015 SHALL treat a byte as transferred only in a cycle with tx_valid=1 and tx_ready=1.
REQ-016 SHALL hold tx_data stable and tx_valid high while tx_valid=1 and tx_ready=0.
REQ-017 SHALL never deassert tx_valid without a transfer except on rst.
REQ-018 SHALL assert tx_valid the cycle after start is sampled, with tx_data = first byte of line 1.
REQ-019 SHALL sustain one byte per cycle within a line when tx_ready is held high; NEXT may insert at most one idle cycle (tx_valid=0) between lines.
REQ-020 SHALL pulse done for exactly one cycle, in the cycle after the final terminator byte transfers, with busy deasserting in that same cycle.
REQ-021 SHALL ignore start while busy=1; start coincident with done's cycle is also ignored.
REQ-022 SHALL emit exactly one run per accepted start; a new start after done restarts from N=1.

Reset
REQ-023 SHALL on rst force state IDLE, N=1, mod counters to N=1 values, tx_valid=0, tx_data=0x00, busy=0, done=0.
REQ-024 SHALL abort any run mid-line on rst with no further bytes offered; rst has priority over start.

Configuration
REQ-025 SHALL use macro FIZZBUZZ_CRLF_EN: defined -> terminator is 0x0D 0x0A ("\r\n"); undefined -> terminator is 0x0A only.

Verification
REQ-026 SHALL cover: MAX_N=15, CRLF on, tx_ready=1 constant, start pulse -> 73 bytes "1\r\n2\r\nFizz\r\n4\r\nBuzz\r\n...14\r\nFizzBuzz\r\n", done one cycle after final 0x0A.
REQ-027 SHALL cover: MAX_N=15, CRLF off -> 58 bytes, each line ending 0x0A only, no 0x0D anywhere.
REQ-028 SHALL cover: MAX_N=100, tx_ready random 30% duty -> byte stream identical to constant-ready run, tx_data never changes while tx_valid=1 and tx_ready=0; lines 97 "97", 99 "Fizz", 100 "Buzz".
REQ-029 SHALL cover: rst asserted during line 10 "Buzz" after 2 bytes -> tx_valid=0 next cycle, busy=0; following start restarts with "1".
REQ-030 SHALL cover: start pulsed while busy and in done cycle -> ignored, exactly one run of MAX_N lines observed.

Source files
------------

// File: rtl/fizzbuzz_tx_gen.sv
// FizzBuzz 1..MAX_N as an ASCII byte stream over a valid/ready handshake to a UART transmitter.
// Define FIZZBUZZ_CRLF_EN to end each line with "\r\n"; otherwise lines end with "\n" only.
module fizzbuzz_tx_gen #(
  parameter int unsigned MAX_N = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StWord, StDigits, StTerm, StNext} state_e;

  localparam logic [3:0] MaxH = 4'(MAX_N / 100);
  localparam logic [3:0] MaxT = 4'((MAX_N / 10) % 10);
  localparam logic [3:0] MaxO = 4'(MAX_N % 10);

`ifdef FIZZBUZZ_CRLF_EN
  localparam logic [2:0] TermLast = 3'd1;
`else
  localparam logic [2:0] TermLast = 3'd0;
`endif

  // Word bytes: "Fizz" for idx 0..3 when fizz, "Buzz" otherwise or for idx 4..7 of "FizzBuzz".
  function automatic logic [7:0] word_byte(input logic fizz, input logic [2:0] idx);
    logic       sel_buzz;
    logic [7:0] b;
    sel_buzz = !fizz || idx[2];
    case (idx[1:0])
      2'd0:    b = sel_buzz ? 8'h42 : 8'h46;
      2'd1:    b = sel_buzz ? 8'h75 : 8'h69;
      default: b = 8'h7A;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] word_last(input logic fizz, input logic buzz);
    return (fizz && buzz) ? 3'd7 : 3'd3;
  endfunction

  function automatic logic [2:0] digit_last(input logic [3:0] h, input logic [3:0] t);
    return (h != 4'd0) ? 3'd2 : ((t != 4'd0) ? 3'd1 : 3'd0);
  endfunction

  // Leading zeros are skipped by offsetting idx into the {h, t, o} digit positions.
  function automatic logic [7:0] digit_byte(input logic [3:0] h, input logic [3:0] t,
                                            input logic [3:0] o, input logic [2:0] idx);
    logic [2:0] pos;
    logic [3:0] d;
    pos = 3'd2 - digit_last(h, t) + idx;
    case (pos)
      3'd0:    d = h;
      3'd1:    d = t;
      default: d = o;
    endcase
    return {4'h3, d};
  endfunction

  function automatic logic [7:0] term_byte(input logic [2:0] idx);
    return (idx == TermLast) ? 8'h0A : 8'h0D;
  endfunction

  state_e     state_q;
  logic [2:0] idx_q;
  logic [3:0] h_q, t_q, o_q;
  logic [1:0] m3_q;
  logic [2:0] m5_q;

  logic       cur_fizz, cur_buzz, nxt_fizz, nxt_buzz;
  logic       xfer, at_max, carry_o, carry_t;
  logic [2:0] idx_inc, seg_last;
  logic [7:0] seg_next_byte, cur_first, nxt_first;
  logic [3:0] nxt_h, nxt_t, nxt_o;
  logic [1:0] nxt_m3;
  logic [2:0] nxt_m5;

  always_comb begin
    xfer     = tx_valid && tx_ready;
    at_max   = (h_q == MaxH) && (t_q == MaxT) && (o_q == MaxO);
    idx_inc  = idx_q + 3'd1;
    cur_fizz = (m3_q == 2'd0);
    cur_buzz = (m5_q == 3'd0);

    seg_last      = (state_q == StWord) ? word_last(cur_fizz, cur_buzz) : digit_last(h_q, t_q);
    seg_next_byte = (state_q == StWord) ? word_byte(cur_fizz, idx_inc)
                                        : digit_byte(h_q, t_q, o_q, idx_inc);
    cur_first     = (cur_fizz || cur_buzz) ? word_byte(cur_fizz, 3'd0)
                                           : digit_byte(h_q, t_q, o_q, 3'd0);

    carry_o  = (o_q == 4'd9);
    carry_t  = carry_o && (t_q == 4'd9);
    nxt_o    = carry_o ? 4'd0 : o_q + 4'd1;
    nxt_t    = carry_o ? (carry_t ? 4'd0 : t_q + 4'd1) : t_q;
    nxt_h    = carry_t ? h_q + 4'd1 : h_q;
    nxt_m3   = (m3_q == 2'd2) ? 2'd0 : m3_q + 2'd1;
    nxt_m5   = (m5_q == 3'd4) ? 3'd0 : m5_q + 3'd1;
    nxt_fizz = (nxt_m3 == 2'd0);
    nxt_buzz = (nxt_m5 == 3'd0);
    nxt_first = (nxt_fizz || nxt_buzz) ? word_byte(nxt_fizz, 3'd0)
                                       : digit_byte(nxt_h, nxt_t, nxt_o, 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 3'd0;
      h_q      <= 4'd0;
      t_q      <= 4'd0;
      o_q      <= 4'd1;
      m3_q     <= 2'd1;
      m5_q     <= 3'd1;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          // A start landing in the done cycle belongs to the finished run and is dropped.
          if (start && !done) begin
            state_q  <= (cur_fizz || cur_buzz) ? StWord : StDigits;
            idx_q    <= 3'd0;
            tx_data  <= cur_first;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StWord, StDigits: begin
          if (xfer) begin
            if (idx_q == seg_last) begin
              state_q <= StTerm;
              idx_q   <= 3'd0;
              tx_data <= term_byte(3'd0);
            end else begin
              idx_q   <= idx_inc;
              tx_data <= seg_next_byte;
            end
          end
        end
        StTerm: begin
          if (xfer) begin
            if (idx_q == TermLast) begin
              tx_valid <= 1'b0;
              idx_q    <= 3'd0;
              // Finish straight from here so done lands in the cycle after the last byte.
              if (at_max) begin
                state_q <= StIdle;
                busy    <= 1'b0;
                done    <= 1'b1;
                h_q     <= 4'd0;
                t_q     <= 4'd0;
                o_q     <= 4'd1;
                m3_q    <= 2'd1;
                m5_q    <= 3'd1;
              end else begin
                state_q <= StNext;
              end
            end else begin
              idx_q   <= idx_inc;
              tx_data <= term_byte(idx_inc);
            end
          end
        end
        StNext: begin
          h_q      <= nxt_h;
          t_q      <= nxt_t;
          o_q      <= nxt_o;
          m3_q     <= nxt_m3;
          m5_q     <= nxt_m5;
          idx_q    <= 3'd0;
          state_q  <= (nxt_fizz || nxt_buzz) ? StWord : StDigits;
          tx_data  <= nxt_first;
          tx_valid <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
